// File: rtl/piso_serializer.sv
// Parallel-in / serial-out converter with a one-word hold register in front of
// the shifter, valid/ready handshakes on both sides and a wrapping word counter.
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             serial_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             frame_start,
  output logic             frame_last,
  output logic             busy,
  output logic [7:0]       word_count
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_t;

  state_t           r_state;
  logic             r_hold_full;
  logic [WIDTH-1:0] r_hold;
  logic [WIDTH-1:0] r_shift;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [7:0]       r_word_count;
  logic             r_in_ready;

  logic             w_accept;
  logic             w_bit_hs;
  logic             w_last_hs;
  logic             w_xfer;
  logic [WIDTH-1:0] w_shift_next;

  assign w_accept  = in_valid & r_in_ready;
  assign w_bit_hs  = (r_state == S_SHIFT) & out_ready;
  assign w_last_hs = w_bit_hs & (r_bit_cnt == LAST_CNT);
  // The hold register drains into the shifter either into an idle shifter or
  // exactly on the last-bit handshake, which gives gap-free back-to-back words.
  assign w_xfer    = r_hold_full & ((r_state == S_IDLE) | w_last_hs);

  assign w_shift_next = MSB_FIRST ? {r_shift[WIDTH-2:0], 1'b0}
                                  : {1'b0, r_shift[WIDTH-1:1]};

  // NOTE: pure data storage qualified by a valid flag needs no reset; only the
  // flag does, so this register sits in its own clock-only block.
  always_ff @(posedge clk) begin
    if (w_accept) r_hold <= parallel_in;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_hold_full  <= 1'b0;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_word_count <= '0;
      r_in_ready   <= 1'b0;
    end else begin
      // Accept and transfer are mutually exclusive because in_ready mirrors
      // an empty hold register.
      r_in_ready <= ~(w_accept | (r_hold_full & ~w_xfer));

      if (w_accept)    r_hold_full <= 1'b1;
      else if (w_xfer) r_hold_full <= 1'b0;

      if (w_last_hs) r_word_count <= r_word_count + 8'd1;

      case (r_state)
        S_IDLE: begin
          if (w_xfer) begin
            r_state   <= S_SHIFT;
            r_shift   <= r_hold;
            r_bit_cnt <= '0;
          end
        end
        S_SHIFT: begin
          if (w_bit_hs) begin
            if (w_last_hs) begin
              r_bit_cnt <= '0;
              if (w_xfer) begin
                r_shift <= r_hold;
              end else begin
                r_state <= S_IDLE;
                r_shift <= '0;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + CNT_W'(1);
              r_shift   <= w_shift_next;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // The shifter is cleared whenever it goes idle, so serial_out reads 0 there.
  assign out_valid   = (r_state == S_SHIFT);
  assign serial_out  = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];
  assign frame_start = out_valid & (r_bit_cnt == '0);
  assign frame_last  = out_valid & (r_bit_cnt == LAST_CNT);
  assign busy        = r_hold_full | out_valid;
  assign in_ready    = r_in_ready;
  assign word_count  = r_word_count;

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: accepted words are expanded into an
// expected bit stream that a negedge monitor compares against the serial side.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] parallel_in;
  logic       in_valid;
  logic       in_ready;
  logic       serial_out;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       frame_start;
  logic       frame_last;
  logic       busy;
  logic [7:0] word_count;

  logic [3:0] l_parallel_in;
  logic       l_in_valid;
  logic       l_in_ready;
  logic       l_serial_out;
  logic       l_out_valid;
  logic       l_out_ready = 1'b1;
  logic       l_frame_start;
  logic       l_frame_last;
  logic       l_busy;
  logic [7:0] l_word_count;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .parallel_in(parallel_in), .in_valid(in_valid),
    .in_ready(in_ready), .serial_out(serial_out), .out_valid(out_valid),
    .out_ready(out_ready), .frame_start(frame_start), .frame_last(frame_last),
    .busy(busy), .word_count(word_count)
  );

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .parallel_in(l_parallel_in), .in_valid(l_in_valid),
    .in_ready(l_in_ready), .serial_out(l_serial_out), .out_valid(l_out_valid),
    .out_ready(l_out_ready), .frame_start(l_frame_start), .frame_last(l_frame_last),
    .busy(l_busy), .word_count(l_word_count)
  );

  typedef struct {
    logic b;
    logic fs;
    logic fl;
  } exp_t;

  exp_t       q[$];
  int         hs_cyc[$];
  int         n_pass  = 0;
  int         n_total = 0;
  int         cyc     = 0;
  logic [7:0] exp_wc  = 8'd0;
  bit         chk_wc  = 1'b0;
  bit         or_random = 1'b0;
  logic       or_force  = 1'b1;

  always @(posedge clk) cyc++;

  // Serial-side backpressure owner: random or forced, changed just after the edge.
  always @(posedge clk) begin
    #2;
    out_ready = or_random ? ($urandom_range(0, 3) != 0) : or_force;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Serial order of a 4-bit word: position i of the stream.
  function automatic logic exp_bit(input logic [3:0] w, input int i, input bit msb);
    return msb ? w[3-i] : w[i];
  endfunction

  // Monitor: every serial handshake consumes one expected bit.
  always @(negedge clk) begin
    exp_t e;
    if (chk_wc) begin
      chk_wc = 1'b0;
      check("word_count", 32'(word_count), 32'(exp_wc));
    end
    if (rst && out_valid && out_ready) begin
      check("bit_available", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        check("serial_out",  32'(serial_out),  32'(e.b));
        check("frame_start", 32'(frame_start), 32'(e.fs));
        check("frame_last",  32'(frame_last),  32'(e.fl));
        hs_cyc.push_back(cyc);
        if (e.fl) begin
          exp_wc = exp_wc + 8'd1;
          chk_wc = 1'b1;
        end
      end
    end
    if (rst && !out_valid)
      check("idle_outputs", 32'({serial_out, frame_start, frame_last}), 32'd0);
  end

  // Call only just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [3:0] w);
    int n = 0;
    bit ok = 1'b0;
    parallel_in = w;
    in_valid    = 1'b1;
    while (!ok && n < 500) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      else n++;
    end
    if (!ok) begin
      check("in_ready_timeout", 32'(in_ready), 32'd1);
    end else begin
      for (int i = 0; i < 4; i++)
        q.push_back('{b: exp_bit(w, i, 1'b1), fs: (i == 0), fl: (i == 3)});
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || out_valid) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain_done", 32'(q.size()), 32'd0);
    @(negedge clk);
    check("drained_out_valid", 32'(out_valid), 32'd0);
    check("drained_busy", 32'(busy), 32'd0);
    check("drained_in_ready", 32'(in_ready), 32'd1);
    check("drained_word_count", 32'(word_count), 32'(exp_wc));
  endtask

  initial begin
    int n;
    logic got;
    rst = 1'b0; in_valid = 1'b0; parallel_in = '0;
    l_in_valid = 1'b0; l_parallel_in = '0;

    // Reset state before any clock edge.
    #2;
    check("rst_in_ready",   32'(in_ready),   32'd0);
    check("rst_out_valid",  32'(out_valid),  32'd0);
    check("rst_serial_out", 32'(serial_out), 32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_word_count", 32'(word_count), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("in_ready_before_edge", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    check("in_ready_after_release", 32'(in_ready), 32'd1);

    // LSB-first instance: 4'b0111 must leave as 1,1,1,0.
    l_parallel_in = 4'b0111;
    l_in_valid    = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!l_in_ready && n < 50);
    @(posedge clk);
    #1 l_in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!l_out_valid && n < 50);
      got = l_serial_out;
      check("lsb_bit", 32'(got), 32'(exp_bit(4'b0111, i, 1'b0)));
      check("lsb_frame_start", 32'(l_frame_start), 32'(i == 0));
    end
    @(posedge clk);
    #1;

    // Single word.
    send(4'b1010);
    drain();
    check("wc_after_single", 32'(word_count), 32'd1);

    // Back-to-back words with in_valid held high: 12 bits, no gap.
    @(posedge clk);
    #1;
    hs_cyc.delete();
    send(4'b1010);
    send(4'b0111);
    send(4'b1111);
    drain();
    check("b2b_bit_count", 32'(hs_cyc.size()), 32'd12);
    if (hs_cyc.size() == 12)
      check("b2b_span", 32'(hs_cyc[11] - hs_cyc[0]), 32'd11);
    check("wc_after_b2b", 32'(word_count), 32'd4);

    // Stall for 3 cycles on the second bit of 4'b0111 with a second word queued.
    @(posedge clk);
    #1;
    send(4'b0111);
    n = 0;
    do begin @(negedge clk); n++; end while (!(out_valid && frame_start) && n < 50);
    @(posedge clk);
    #1 or_force = 1'b0;
    send(4'b1100);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("stall_serial_out", 32'(serial_out), 32'd1);
      check("stall_out_valid",  32'(out_valid),  32'd1);
      check("stall_in_ready",   32'(in_ready),   32'd0);
      check("stall_frame_flags", 32'({frame_start, frame_last}), 32'd0);
    end
    @(posedge clk);
    #1 or_force = 1'b1;
    drain();

    // Reset mid-word with a second word held.
    @(posedge clk);
    #1;
    send(4'b1010);
    send(4'b0111);
    #1 rst = 1'b0;
    #1;
    q.delete();
    exp_wc = 8'd0;
    chk_wc = 1'b0;
    check("midrst_out_valid",  32'(out_valid),  32'd0);
    check("midrst_serial_out", 32'(serial_out), 32'd0);
    check("midrst_in_ready",   32'(in_ready),   32'd0);
    check("midrst_busy",       32'(busy),       32'd0);
    check("midrst_word_count", 32'(word_count), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("midrst_in_ready_pre", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    check("midrst_in_ready_post", 32'(in_ready), 32'd1);
    repeat (8) @(negedge clk);
    check("midrst_no_bits", 32'(out_valid), 32'd0);
    check("midrst_busy_after", 32'(busy), 32'd0);

    // 256 consecutive words: counter wraps to 0.
    @(posedge clk);
    #1;
    for (int i = 0; i < 256; i++) send(4'($urandom_range(0, 15)));
    drain();
    check("wc_wrap", 32'(word_count), 32'd0);

    // Random words, random gaps, random backpressure.
    @(posedge clk);
    #1 or_random = 1'b1;
    for (int i = 0; i < 40; i++) begin
      int k;
      send(4'($urandom_range(0, 15)));
      k = $urandom_range(0, 2);
      if (k > 0) begin
        repeat (k) @(posedge clk);
        #1;
      end
    end
    or_random = 1'b0;
    or_force  = 1'b1;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter WIDTH, default 4: parallel word width in bits, legal range 2..16.
REQ-002 Parameter MSB_FIRST, default 1: 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 parallel_in  input  WIDTH  word from the upstream parallel register stage.
REQ-006 in_valid  input  1  parallel_in holds a word to transfer.
REQ-007 in_ready  output  1  block can accept a word this cycle.
REQ-008 serial_out  output  1  current serial bit.
REQ-009 out_valid  output  1  serial_out holds a valid bit.
REQ-010 out_ready  input  1  downstream consumes serial_out this cycle.
REQ-011 frame_start  output  1  current bit is bit 0 of the serial order of a word.
REQ-012 frame_last  output  1  current bit is the final bit of a word.
REQ-013 busy  output  1  hold register or shifter is occupied.
REQ-014 word_count  output  8  count of fully transmitted words, modulo 256.

Function
REQ-015 Input handshake: a word SHALL be accepted on a rising edge where in_valid=1 and in_ready=1, and captured into a one-word hold register.
REQ-016 in_ready SHALL be a registered signal equal to NOT hold_full, with no combinational path from out_ready or in_valid.
REQ-017 The shifter SHALL have two states, IDLE (empty) and SHIFT (word loaded).
REQ-018 Hold-to-shifter transfer SHALL occur on an edge where hold_full=1 and either the state is IDLE, or the state is SHIFT with the last-bit handshake (out_valid & out_ready & frame_last) on that edge. Hold then empties and the state becomes or remains SHIFT.
REQ-019 Latency: a word accepted at edge k with the state IDLE SHALL present its first bit with out_valid=1 after edge k+1.
REQ-020 In SHIFT, out_valid SHALL be 1; in IDLE, out_valid SHALL be 0 and serial_out SHALL be 0.
REQ-021 The bit counter SHALL advance only on out_valid & out_ready. When out_ready=0, serial_out, frame_start and frame_last SHALL hold their values.
REQ-022 frame_start SHALL be out_valid & (bit_cnt==0); frame_last SHALL be out_valid & (bit_cnt==WIDTH-1).
REQ-023 When the last-bit handshake occurs with hold empty, the state SHALL return to IDLE. When it occurs with hold full, the next word SHALL start on the following cycle with no idle bit between words.
REQ-024 Hold transfer and a new input acceptance SHALL NOT occur on the same edge, because in_ready was 0 while hold was full. The hold register SHALL never be overwritten.
REQ-025 word_count SHALL increment by 1 on each last-bit handshake and wrap from 255 to 0.
REQ-026 busy SHALL be hold_full OR (state==SHIFT).

Reset
REQ-027 When rst=0, the block SHALL immediately, without waiting for a clock edge, set: state IDLE, hold_full=0, bit_cnt=0, word_count=0, serial_out=0, out_valid=0, in_ready=0, busy=0.
REQ-028 in_ready SHALL go to 1 on the first rising edge after rst returns to 1.
REQ-029 Asserting rst mid-word SHALL discard the partial word and any held word. No further bits of those words SHALL appear after reset is released.

Verification
REQ-030 WIDTH=4, MSB_FIRST=1, out_ready=1, one word 4'b1010 -> serial_out sequence 1,0,1,0 on 4 consecutive cycles. frame_start is set on the first bit only, frame_last on the fourth only, then out_valid=0 and word_count=1.
REQ-031 Back-to-back words 4'b1010, 4'b0111, 4'b1111, with in_valid held high -> 12 consecutive valid bits 1010 0111 1111 with no out_valid gap, and word_count=3.
REQ-032 out_ready=0 for 3 cycles during bit 2 of 4'b0111 -> serial_out stays 1 and out_valid stays 1 throughout. Transmission resumes with the correct remaining bits; with a second word waiting, in_ready=0 until its transfer.
REQ-033 rst pulsed low during bit 1 of 4'b1010, with 4'b0111 held -> outputs match REQ-027 at once. After release, no bits of either word appear and in_ready=1 one edge after release.
REQ-034 MSB_FIRST=0, word 4'b0111 -> serial_out sequence 1,1,1,0.
REQ-035 256 consecutive words -> word_count wraps to 0 on the 256th last-bit handshake.
